// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Purpose:
//   Receives a byte stream through a valid/ready handshake and writes it into
//   instruction memory. The stream starts with a 16-bit big-endian word
//   count N. It is followed by N words, each sent MSB first. Words are written
//   sequentially from byte address 0. While a load is pending or in progress,
//   the processor is held in reset with its clock-enable low. It is released
//   once the final word has been written.
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   start               single-cycle pulse; begins a load from IDLE/RUN/ERR
//   in_data, in_valid   incoming stream byte and its valid flag
//   in_ready            loader accepts a byte this cycle
//   imem_we             one-cycle write strobe per assembled word
//   imem_addr           word-aligned byte address of the write
//   imem_wdata          assembled 32-bit instruction word
//   cpu_ce, cpu_rst     processor clock-enable / reset (running only in RUN)
//   busy, done, err     load in progress / load complete / load failed
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_ce,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // word_idx needs one extra bit so that it can hold N == DEPTH_WORDS
    // without wrapping.
    localparam int WIDX_W = $clog2(DEPTH_WORDS) + 1;
    // The idle counter only ever holds values 0 .. TIMEOUT_CYC-1.
    localparam int IDLE_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST =
        IDLE_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [16:0] DEPTH_N = 17'(DEPTH_WORDS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR_HI = 3'd1,
        S_HDR_LO = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_RUN    = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          hdr_hi_q, hdr_hi_d;
    logic [15:0]         n_q, n_d;
    logic [23:0]         asm_q, asm_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [WIDX_W-1:0]   word_idx_q, word_idx_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;

    logic                xfer;
    logic                timed_out;
    logic [15:0]         n_full;
    logic [WIDX_W-1:0]   word_next;

    // Outputs are decoded purely from the registered state, so in_ready has
    // no combinational dependence on in_valid.
    assign in_ready   = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) ||
                        (state_q == S_DATA);
    assign imem_we    = (state_q == S_WRITE);
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_ce     = (state_q == S_RUN);
    assign cpu_rst    = (state_q != S_RUN);
    assign done       = (state_q == S_RUN);
    assign err        = (state_q == S_ERR);
    assign busy       = in_ready || (state_q == S_WRITE);

    assign xfer = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            hdr_hi_q   <= '0;
            n_q        <= '0;
            asm_q      <= '0;
            byte_idx_q <= '0;
            word_idx_q <= '0;
            idle_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            hdr_hi_q   <= hdr_hi_d;
            n_q        <= n_d;
            asm_q      <= asm_d;
            byte_idx_q <= byte_idx_d;
            word_idx_q <= word_idx_d;
            idle_q     <= idle_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hdr_hi_d   = hdr_hi_q;
        n_d        = n_q;
        asm_d      = asm_q;
        byte_idx_d = byte_idx_q;
        word_idx_d = word_idx_q;
        idle_d     = idle_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        timed_out  = 1'b0;
        n_full     = {hdr_hi_q, in_data};
        word_next  = word_idx_q + WIDX_W'(1);

        // Inter-byte timeout: counts stalled cycles in the byte-accepting
        // states. A transfer always wins over expiry.
        if (in_ready) begin
            if (xfer) begin
                idle_d = '0;
            end else if (TIMEOUT_CYC != 0) begin
                if (idle_q == IDLE_LAST) begin
                    timed_out = 1'b1;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end
        end

        case (state_q)
            S_IDLE, S_RUN, S_ERR: begin
                if (start) begin
                    state_d = S_HDR_HI;
                    idle_d  = '0;
                end
            end
            S_HDR_HI: begin
                if (xfer) begin
                    hdr_hi_d = in_data;
                    state_d  = S_HDR_LO;
                end
            end
            S_HDR_LO: begin
                if (xfer) begin
                    n_d = n_full;
                    if ((n_full == 16'd0) || ({1'b0, n_full} > DEPTH_N)) begin
                        state_d = S_ERR;
                    end else begin
                        byte_idx_d = '0;
                        word_idx_d = '0;
                        state_d    = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    asm_d      = {asm_q[15:0], in_data};
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        // Latch the write now so that address and data are
                        // stable registers for the whole WRITE cycle.
                        wdata_d = {asm_q, in_data};
                        addr_d  = ADDR_W'({word_idx_q, 2'b00});
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                word_idx_d = word_next;
                byte_idx_d = '0;
                if ({1'b0, n_q} == 17'(word_next)) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_DATA;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (timed_out) begin
            state_d = S_ERR;
            idle_d  = '0;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//
// Purpose:
//   Testbench for imem_loader (DEPTH_WORDS=256, TIMEOUT_CYC=10). Stimulus
//   pushes each expected memory write into a scoreboard queue. A monitor
//   on the falling clock edge pops an entry from the queue on every imem_we
//   and compares it with the observed write. It also checks that in_ready is
//   low exactly on write cycles while busy. State and output flags are
//   checked directly by the stimulus process.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_ce;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] bq[$];

    imem_loader #(
        .DEPTH_WORDS(256),
        .ADDR_W     (32),
        .TIMEOUT_CYC(10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_ce    (cpu_ce),
        .cpu_rst   (cpu_rst),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end else begin
            $display("ok   %s = %b", name, got);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end else begin
            $display("ok   %s = %h", name, got);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        wr_t e;
        if (!rst) begin
            if (busy) begin
                checks++;
                if (in_ready !== !imem_we) begin
                    errors++;
                    $display("FAIL ready_vs_write in_ready=%b imem_we=%b", in_ready, imem_we);
                end
            end
            if (imem_we) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr=%h data=%h", imem_addr, imem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (imem_addr !== e.addr || imem_wdata !== e.data) begin
                        errors++;
                        $display("FAIL write got addr=%h data=%h exp addr=%h data=%h",
                                 imem_addr, imem_wdata, e.addr, e.data);
                    end else begin
                        $display("ok   write addr=%h data=%h", imem_addr, imem_wdata);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Presents one byte after 'gap' cycles with in_valid low, holds it until
    // accepted (bounded), then drops in_valid. Returns 1ns after the edge on
    // which the transfer occurred.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int   n;
        logic got;
        logic fin;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = b;
        n   = 0;
        fin = 1'b0;
        while (!fin) begin
            @(negedge clk);
            got = in_ready;
            tick();
            if (got) begin
                fin = 1'b1;
            end else begin
                n++;
                if (n > 50) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout byte=%h not accepted in 50 cycles", b);
                    fin = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_all(input int maxgap);
        foreach (bq[i]) send_byte(bq[i], $urandom_range(0, maxgap));
    endtask

    task automatic check_run(input string tag);
        chk1({tag, "_done"},    done,     1'b1);
        chk1({tag, "_cpu_ce"},  cpu_ce,   1'b1);
        chk1({tag, "_cpu_rst"}, cpu_rst,  1'b0);
        chk1({tag, "_err"},     err,      1'b0);
        chk1({tag, "_busy"},    busy,     1'b0);
        chk1({tag, "_ready"},   in_ready, 1'b0);
        chk32({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_err(input string tag);
        chk1({tag, "_err"},     err,      1'b1);
        chk1({tag, "_cpu_ce"},  cpu_ce,   1'b0);
        chk1({tag, "_cpu_rst"}, cpu_rst,  1'b1);
        chk1({tag, "_done"},    done,     1'b0);
        chk1({tag, "_busy"},    busy,     1'b0);
        chk1({tag, "_ready"},   in_ready, 1'b0);
    endtask

    task automatic check_reset_outs(input string tag);
        chk1({tag, "_ready"},   in_ready, 1'b0);
        chk1({tag, "_we"},      imem_we,  1'b0);
        chk32({tag, "_addr"},   imem_addr,  32'h0);
        chk32({tag, "_wdata"},  imem_wdata, 32'h0);
        chk1({tag, "_cpu_ce"},  cpu_ce,   1'b0);
        chk1({tag, "_cpu_rst"}, cpu_rst,  1'b1);
        chk1({tag, "_busy"},    busy,     1'b0);
        chk1({tag, "_done"},    done,     1'b0);
        chk1({tag, "_err"},     err,      1'b0);
    endtask

    initial begin
        logic [7:0] b8;
        rst      = 1'b1;
        start    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        repeat (2) tick();
        check_reset_outs("reset");
        rst = 1'b0;
        tick();
        chk1("idle_not_ready", in_ready, 1'b0);

        // 1: two-word load, back to back.
        push_wr(32'h0, 32'h20080005);
        push_wr(32'h4, 32'h00000000);
        pulse_start();
        chk1("t1_busy", busy, 1'b1);
        bq = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
        send_all(0);
        tick();
        check_run("t1");

        // 2: same stream with random gaps (reload from RUN).
        push_wr(32'h0, 32'h20080005);
        push_wr(32'h4, 32'h00000000);
        pulse_start();
        send_all(5);
        tick();
        check_run("t2");

        // 3: N=0 and N=257 rejected, then a valid 1-word load recovers.
        pulse_start();
        bq = '{8'h00, 8'h00};
        send_all(0);
        check_err("t3_n0");
        pulse_start();
        chk1("t3_err_clear", err, 1'b0);
        bq = '{8'h01, 8'h01};
        send_all(0);
        check_err("t3_n257");
        push_wr(32'h0, 32'hDEADBEEF);
        pulse_start();
        bq = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_all(0);
        tick();
        check_run("t3_ok");

        // 4: timeout after 10 idle cycles; a 9-cycle stall is tolerated.
        pulse_start();
        bq = '{8'h00, 8'h01, 8'hAA, 8'hBB};
        send_all(0);
        repeat (9) tick();
        chk1("t4_9idle_busy", busy, 1'b1);
        chk1("t4_9idle_err",  err,  1'b0);
        tick();
        check_err("t4_timeout");
        push_wr(32'h0, 32'hAABBCCDD);
        pulse_start();
        send_all(0);
        send_byte(8'hCC, 9);
        send_byte(8'hDD, 0);
        tick();
        check_run("t4_stall9");

        // 5: bytes offered in RUN are not consumed; reload; start in DATA ignored.
        in_valid = 1'b1;
        in_data  = 8'h00;
        repeat (3) begin
            @(negedge clk);
            chk1("t5_run_not_ready", in_ready, 1'b0);
        end
        tick();
        chk1("t5_still_run", done, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk1("t5_cpu_ce_fell",  cpu_ce,  1'b0);
        chk1("t5_cpu_rst_high", cpu_rst, 1'b1);
        chk1("t5_busy",         busy,    1'b1);
        push_wr(32'h0, 32'h8C090004);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h8C, 0);
        pulse_start();
        chk1("t5_start_ignored_busy", busy, 1'b1);
        chk1("t5_start_ignored_done", done, 1'b0);
        send_byte(8'h09, 0);
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        tick();
        check_run("t5");

        // 6: asynchronous reset in the middle of word 2.
        push_wr(32'h0, 32'h11223344);
        push_wr(32'h4, 32'h55667788);
        pulse_start();
        bq = '{8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44,
               8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
        send_all(0);
        chk32("t6_addr_before_rst", imem_addr, 32'h4);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outs("t6_async");
        chk32("t6_two_writes_only", 32'(exp_q.size()), 32'd0);
        rst = 1'b0;
        tick();
        chk1("t6_idle_busy",  busy,     1'b0);
        chk1("t6_idle_ready", in_ready, 1'b0);

        // 7: maximum load, N = DEPTH_WORDS = 256.
        bq = '{8'h01, 8'h00};
        for (int i = 0; i < 256; i++) begin
            b8 = 8'(i);
            push_wr(32'(i * 4), {b8, ~b8, 8'hC3, b8 ^ 8'h3C});
            bq.push_back(b8);
            bq.push_back(~b8);
            bq.push_back(8'hC3);
            bq.push_back(b8 ^ 8'h3C);
        end
        pulse_start();
        send_all(0);
        tick();
        check_run("t7_full");
        chk32("t7_last_addr", imem_addr, 32'h3FC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
